fc_flatten_sequencer: RTL

//  Upstream feeder and sequencer for the FC stage (TOP_MODULE_FC).
//  - Accepts the pooled feature map as a valid/ready stream in pixel-major order (channel fastest).
//  - Writes it into FC input memory channel-major via the ex_we/ex_value/ex_addr port.
//  - Then runs the FC handshake sequence: enable, back-propagation, mini-batch end.
//  - Counts samples so batch_end is raised once every BATCH_SIZE samples.
//

---
 rtl/cnn_fc_pkg.sv | 21 ++
 rtl/flatten_addr_gen.sv | 66 ++++++
 rtl/fc_flatten_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cnn_fc_pkg.sv
// Shared widths, sequencer state type and flatten-geometry helper for the FC feeder slice.
package cnn_fc_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_BPROP_REQ,
        S_BPROP_WAIT,
        S_BATCH_REQ,
        S_BATCH_WAIT
    } seq_state_t;

    function automatic int flatLen(input int channels, input int mapH, input int mapW);
        return channels * mapH * mapW;
    endfunction

endpackage

// File: rtl/flatten_addr_gen.sv
// Walks ch (fastest), col, row over a pixel-major stream and produces the
// channel-major FC input-memory address using only incremental adds.
module flatten_addr_gen
    import cnn_fc_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int MAP_H     = 7,
    parameter int MAP_W     = 1,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_ex_addr,
    output logic              o_last
);

    localparam logic [ADDR_W-1:0] CH_MAX  = ADDR_W'(CHANNELS - 1);
    localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'(MAP_H - 1);
    localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(MAP_W - 1);
    localparam logic [ADDR_W-1:0] PLANE   = ADDR_W'(MAP_H * MAP_W);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

    logic [ADDR_W-1:0] r_ch;
    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_pixAddr;
    logic [ADDR_W-1:0] r_addr;

    // r_pixAddr is the channel-0 address of the current pixel; row*W+col steps by one per pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ch      <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_pixAddr <= BASE;
            r_addr    <= BASE;
        end else if (i_clear) begin
            r_ch      <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_pixAddr <= BASE;
            r_addr    <= BASE;
        end else if (i_advance) begin
            if (r_ch == CH_MAX) begin
                r_ch      <= '0;
                r_pixAddr <= r_pixAddr + 16'd1;
                r_addr    <= r_pixAddr + 16'd1;
                if (r_col == COL_MAX) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_MAX) ? '0 : r_row + 16'd1;
                end else begin
                    r_col <= r_col + 16'd1;
                end
            end else begin
                r_ch   <= r_ch + 16'd1;
                r_addr <= r_addr + PLANE;
            end
        end
    end

    assign o_ex_addr = r_addr;
    assign o_last    = (r_ch == CH_MAX) && (r_row == ROW_MAX) && (r_col == COL_MAX);

endmodule

// File: rtl/fc_flatten_sequencer.sv
// Loads one pooled sample into FC input memory, then drives the FC
// enable / back-prop / mini-batch handshake and counts samples per batch.
module fc_flatten_sequencer
    import cnn_fc_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int MAP_H      = 7,
    parameter int MAP_W      = 1,
    parameter int BASE_ADDR  = 0,
    parameter int BATCH_SIZE = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              ex_we,
    output logic [DATA_W-1:0] ex_value,
    output logic [ADDR_W-1:0] ex_addr,
    output logic              enable,
    input  logic              all_end,
    output logic              bck_prop_start,
    input  logic              fc_bck_prop_end,
    output logic              batch_end,
    input  logic              fc_batch_end,
    output logic              busy,
    output logic              sample_done,
    output logic [5:0]        sample_cnt
);

    localparam int FLAT_LEN = flatLen(CHANNELS, MAP_H, MAP_W);
    localparam logic [5:0] LAST_SAMPLE = 6'(BATCH_SIZE - 1);

    if (FLAT_LEN + BASE_ADDR > 65536) begin : g_geometryTooLarge
        $error("fc_flatten_sequencer: flatten span exceeds the 16-bit address space");
    end

    seq_state_t        r_state;
    logic              r_exWe;
    logic [DATA_W-1:0] r_exValue;
    logic [ADDR_W-1:0] r_exAddr;
    logic              r_enable;
    logic              r_bckProp;
    logic              r_batchEnd;
    logic              r_sampleDone;
    logic [5:0]        r_sampleCnt;

    logic              w_clear;
    logic              w_accept;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last;

    assign w_clear  = (r_state == S_IDLE) && start;
    assign w_accept = (r_state == S_LOAD) && in_valid;

    flatten_addr_gen #(
        .CHANNELS (CHANNELS),
        .MAP_H    (MAP_H),
        .MAP_W    (MAP_W),
        .BASE_ADDR(BASE_ADDR)
    ) u_addrGen (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clear  (w_clear),
        .i_advance(w_accept),
        .o_ex_addr(w_addr),
        .o_last   (w_last)
    );

    // Pulse outputs default low each cycle; enable only rises once the final write has left.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_exWe       <= 1'b0;
            r_exValue    <= '0;
            r_exAddr     <= '0;
            r_enable     <= 1'b0;
            r_bckProp    <= 1'b0;
            r_batchEnd   <= 1'b0;
            r_sampleDone <= 1'b0;
            r_sampleCnt  <= '0;
        end else begin
            r_exWe       <= 1'b0;
            r_bckProp    <= 1'b0;
            r_batchEnd   <= 1'b0;
            r_sampleDone <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_exWe    <= 1'b1;
                        r_exValue <= in_data;
                        r_exAddr  <= w_addr;
                        if (w_last) r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (all_end) begin
                        r_enable  <= 1'b0;
                        r_bckProp <= 1'b1;
                        r_state   <= S_BPROP_REQ;
                    end else begin
                        r_enable <= 1'b1;
                    end
                end
                S_BPROP_REQ: begin
                    r_state <= S_BPROP_WAIT;
                end
                S_BPROP_WAIT: begin
                    if (fc_bck_prop_end) begin
                        r_sampleDone <= 1'b1;
                        if (r_sampleCnt == LAST_SAMPLE) begin
                            r_batchEnd <= 1'b1;
                            r_state    <= S_BATCH_REQ;
                        end else begin
                            r_sampleCnt <= r_sampleCnt + 6'd1;
                            r_state     <= S_IDLE;
                        end
                    end
                end
                S_BATCH_REQ: begin
                    r_state <= S_BATCH_WAIT;
                end
                S_BATCH_WAIT: begin
                    if (fc_batch_end) begin
                        r_sampleCnt <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready       = (r_state == S_LOAD);
    assign busy           = (r_state != S_IDLE);
    assign ex_we          = r_exWe;
    assign ex_value       = r_exValue;
    assign ex_addr        = r_exAddr;
    assign enable         = r_enable;
    assign bck_prop_start = r_bckProp;
    assign batch_end      = r_batchEnd;
    assign sample_done    = r_sampleDone;
    assign sample_cnt     = r_sampleCnt;

endmodule
